// File: rtl/cs_symbol_collector.sv
// Collects K indexed symbols from a serial valid/ready stream into one parallel frame.
// Optional idle timeout closes partial frames when CS_COLLECT_TIMEOUT_EN is defined.
module cs_symbol_collector #(
   parameter int K       = 5,
   parameter int L       = 11,
   parameter int IW      = (K > 1) ? $clog2(K) : 1,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 s_valid_i,
   output logic                 s_ready_o,
   input  logic [L-2:0]         s_data_i,
   input  logic [IW-1:0]        s_idx_i,
   input  logic                 s_last_i,
   output logic                 m_valid_o,
   input  logic                 m_ready_i,
   output logic [K*(L-1)-1:0]   m_data_o,
   output logic [K-1:0]         m_present_o,
   output logic                 m_complete_o,
   output logic                 m_timeout_o,
   output logic                 err_idx_o,
   output logic                 err_dup_o,
   output logic [15:0]          frame_cnt_o
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COLLECT = 2'd1;
   localparam logic [1:0] HOLD    = 2'd2;
   localparam logic [IW:0] K_LIM  = (IW+1)'(K);

   logic [1:0]   r_state;
   logic [K-1:0] r_present;
   logic [L-2:0] r_slot [K];
   logic         r_err_idx;
   logic         r_err_dup;
   logic [15:0]  r_frame_cnt;

   logic         w_accept;
   logic         w_idx_ok;
   logic [K-1:0] w_sel;
   logic [K-1:0] w_present_next;
   logic         w_dup;
   logic         w_close;
   logic         w_out_hs;
   logic         w_tmo;

   assign s_ready_o      = (r_state != HOLD);
   assign m_valid_o      = (r_state == HOLD);
   assign w_accept       = s_valid_i & s_ready_o;
   assign w_idx_ok       = ({1'b0, s_idx_i} < K_LIM);
   assign w_out_hs       = m_valid_o & m_ready_i;
   assign w_present_next = r_present | w_sel;
   assign w_dup          = |(w_sel & r_present);
   // A beat closes on s_last_i or when it fills the last empty slot, even if its own index is bad.
   assign w_close        = w_accept & (s_last_i | (&w_present_next));

   genvar gi;
   generate
      for (gi = 0; gi < K; gi++) begin : g_slot
         assign w_sel[gi] = w_accept & w_idx_ok & (s_idx_i == IW'(gi));

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               r_slot[gi] <= '0;
            end else if (w_out_hs) begin
               r_slot[gi] <= '0;
            end else if (w_sel[gi] & ~r_present[gi]) begin
               r_slot[gi] <= s_data_i;
            end
         end

         assign m_data_o[gi*(L-1) +: (L-1)] = r_slot[gi];
      end
   endgenerate

`ifdef CS_COLLECT_TIMEOUT_EN
   localparam logic [15:0] TMO_LIM = 16'(TIMEOUT);
   logic [15:0] r_idle_cnt;
   logic        r_timeout;

   assign w_tmo       = (r_state == COLLECT) & ~w_accept & (r_idle_cnt == TMO_LIM);
   assign m_timeout_o = r_timeout;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_idle_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         if ((r_state == COLLECT) && !w_accept && !w_tmo) begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
         end else begin
            r_idle_cnt <= '0;
         end
         if (w_tmo) begin
            r_timeout <= 1'b1;
         end else if (w_out_hs) begin
            r_timeout <= 1'b0;
         end
      end
   end
`else
   logic w_unused_tmo;
   assign w_unused_tmo = (TIMEOUT < 0);
   assign w_tmo        = 1'b0;
   assign m_timeout_o  = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         r_present   <= '0;
         r_err_idx   <= 1'b0;
         r_err_dup   <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_err_idx <= w_accept & ~w_idx_ok;
         r_err_dup <= w_dup;
         case (r_state)
            IDLE, COLLECT: begin
               if (w_close || w_tmo) begin
                  r_state <= HOLD;
               end else if (w_accept) begin
                  r_state <= COLLECT;
               end
               r_present <= w_present_next;
            end
            HOLD: begin
               if (w_out_hs) begin
                  r_state     <= IDLE;
                  r_present   <= '0;
                  r_frame_cnt <= r_frame_cnt + 16'd1;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_present <= '0;
            end
         endcase
      end
   end

   assign m_present_o  = r_present;
   assign m_complete_o = &r_present;
   assign err_idx_o    = r_err_idx;
   assign err_dup_o    = r_err_dup;
   assign frame_cnt_o  = r_frame_cnt;

endmodule
